hbridge_multi_ctrl: RTL and testbench

- Parametrised successor to the single H-bridge dead-time controller in the CPLD firmware.
- Drives N_BRIDGES independent full H-bridges with:
  - programmable dead time,
  - per-channel enable (coast) and brake modes,
  - input synchronisers,
  - latched shutdown from the shared hardware-fault inputs.
- Sits between the MCU control pins and the gate-driver pins. Outputs are tristated by the active-low GTS1 pin.

---
 rtl/hbridge_pkg.sv | 16 +
 rtl/hbridge_channel.sv | 37 +++
 rtl/hbridge_multi_ctrl.sv | 73 +++++++
 tb/tb_hbridge_multi_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared state encoding, drive patterns and synchroniser depth for the H-bridge controller.
//   state_t     : channel states (OFF, DEAD, FWD, REV, BRAKE)
//   DRV_*       : gate-drive patterns ordered {HL, LL, HR, LR}
//   SYNC_STAGES : flops in every input synchroniser
//   drive_of()  : state to drive-pattern decode
package hbridge_pkg;
    typedef enum logic [2:0] {ST_OFF, ST_DEAD, ST_FWD, ST_REV, ST_BRAKE} state_t;
    localparam logic [3:0] DRV_OFF   = 4'b0000;
    localparam logic [3:0] DRV_FWD   = 4'b1001;
    localparam logic [3:0] DRV_REV   = 4'b0110;
    localparam logic [3:0] DRV_BRAKE = 4'b0101;
    localparam int SYNC_STAGES = 2;
    function automatic logic [3:0] drive_of(input state_t s);
        return s == ST_FWD ? DRV_FWD : s == ST_REV ? DRV_REV : s == ST_BRAKE ? DRV_BRAKE : DRV_OFF;
    endfunction
endpackage

// File: rtl/hbridge_channel.sv
// hbridge_channel: one H-bridge state machine with dead-time insertion and registered drive decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : requested state (ST_OFF, ST_FWD, ST_REV or ST_BRAKE)
//   drive      : registered gate drive {HL, LL, HR, LR}
module hbridge_channel import hbridge_pkg::*; #(
    parameter int DEAD_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  state_t     req,
    output logic [3:0] drive
);
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
    state_t state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    // OFF is always safe and immediate; any other change goes through DEAD, and
    // DEAD exits to whatever is requested when the counter reaches zero.
    always_comb begin
        nxt = req == ST_OFF ? ST_OFF :
              state == ST_DEAD ? (cnt == '0 ? req : ST_DEAD) :
              req != state ? ST_DEAD : state;
        cnt_nxt = nxt != ST_DEAD ? '0 :
                  state == ST_DEAD ? cnt - CNT_W'(1) : CNT_W'(DEAD_CYCLES - 1);
    end
    // Drive is decoded from the next state so it changes on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            cnt   <= '0;
            drive <= DRV_OFF;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            drive <= drive_of(nxt);
        end
    end
endmodule

// File: rtl/hbridge_multi_ctrl.sv
// hbridge_multi_ctrl: N independent dead-time H-bridge controllers with shared latched fault shutdown.
//   GCK1                 : system clock
//   GSR1                 : asynchronous active-low reset
//   GTS1                 : active-low output enable; high tristates all drive outputs
//   pwm/enable/brake     : per-channel direction, enable (0 = coast) and brake requests
//   no_overcurrent, no_hardware_error, heatsink_temp_ok : active-low fault inputs
//   fault_clear          : rising edge clears the latched fault when no fault is present
//   drive{High,Low}{Left,Right} : per-channel gate drives
//   fault_latched        : 1 while shutdown is latched (set by reset)
module hbridge_multi_ctrl import hbridge_pkg::*; #(
    parameter int N_BRIDGES   = 2,
    parameter int DEAD_CYCLES = 12
) (
    input  logic                 GCK1,
    input  logic                 GSR1,
    input  logic                 GTS1,
    input  logic [N_BRIDGES-1:0] pwm,
    input  logic [N_BRIDGES-1:0] enable,
    input  logic [N_BRIDGES-1:0] brake,
    input  logic                 no_overcurrent,
    input  logic                 no_hardware_error,
    input  logic                 heatsink_temp_ok,
    input  logic                 fault_clear,
    output logic [N_BRIDGES-1:0] driveHighLeft,
    output logic [N_BRIDGES-1:0] driveLowLeft,
    output logic [N_BRIDGES-1:0] driveHighRight,
    output logic [N_BRIDGES-1:0] driveLowRight,
    output logic                 fault_latched
);
    localparam int W = 3 * N_BRIDGES + 4;
    // All asynchronous inputs share one synchroniser chain; the last stage is s.
    logic [SYNC_STAGES-1:0][W-1:0] sync;
    logic [W-1:0] raw, s;
    logic [N_BRIDGES-1:0] hl, ll, hr, lr;
    logic clr_prev, clr_rise, fault_now;
    assign raw       = {fault_clear, heatsink_temp_ok, no_hardware_error, no_overcurrent, brake, enable, pwm};
    assign s         = sync[SYNC_STAGES-1];
    assign fault_now = ~&s[W-2:W-4];
    assign clr_rise  = s[W-1] & ~clr_prev;
    // Fault has priority over a simultaneous clear.
    always_ff @(posedge GCK1 or negedge GSR1) begin
        if (!GSR1) begin
            sync          <= '0;
            clr_prev      <= 1'b0;
            fault_latched <= 1'b1;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], raw};
            clr_prev      <= s[W-1];
            fault_latched <= fault_now | (fault_latched & ~clr_rise);
        end
    end
    // The unlatched fault also forces OFF so channels shut down on the edge that latches it.
    for (genvar i = 0; i < N_BRIDGES; i++) begin : g_ch
        state_t req;
        logic [3:0] drv;
        assign req = (!s[N_BRIDGES+i] || fault_latched || fault_now) ? ST_OFF :
                     s[2*N_BRIDGES+i] ? ST_BRAKE : s[i] ? ST_FWD : ST_REV;
        hbridge_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_ch (
            .clk   (GCK1),
            .rst_n (GSR1),
            .req   (req),
            .drive (drv)
        );
        assign hl[i] = drv[3];
        assign ll[i] = drv[2];
        assign hr[i] = drv[1];
        assign lr[i] = drv[0];
    end
    assign driveHighLeft  = GTS1 ? 'z : hl;
    assign driveLowLeft   = GTS1 ? 'z : ll;
    assign driveHighRight = GTS1 ? 'z : hr;
    assign driveLowRight  = GTS1 ? 'z : lr;
endmodule

// File: tb/tb_hbridge_multi_ctrl.sv
// tb_hbridge_multi_ctrl: directed bench for hbridge_multi_ctrl with DEAD_CYCLES=12, N_BRIDGES=2.
module tb_hbridge_multi_ctrl;
    logic GCK1 = 1'b0;
    logic GSR1, GTS1, no_overcurrent, no_hardware_error, heatsink_temp_ok, fault_clear;
    logic [1:0] pwm, enable, brake;
    logic [1:0] driveHighLeft, driveLowLeft, driveHighRight, driveLowRight;
    logic fault_latched;
    int checks = 0;
    int errors = 0;
    int shoot = 0;

    hbridge_multi_ctrl #(.N_BRIDGES(2), .DEAD_CYCLES(12)) dut (
        .GCK1              (GCK1),
        .GSR1              (GSR1),
        .GTS1              (GTS1),
        .pwm               (pwm),
        .enable            (enable),
        .brake             (brake),
        .no_overcurrent    (no_overcurrent),
        .no_hardware_error (no_hardware_error),
        .heatsink_temp_ok  (heatsink_temp_ok),
        .fault_clear       (fault_clear),
        .driveHighLeft     (driveHighLeft),
        .driveLowLeft      (driveLowLeft),
        .driveHighRight    (driveHighRight),
        .driveLowRight     (driveLowRight),
        .fault_latched     (fault_latched)
    );

    always #5 GCK1 = ~GCK1;

    always @(negedge GCK1)
        if (GSR1 && !GTS1 && ((driveHighLeft & driveLowLeft) | (driveHighRight & driveLowRight)) != 2'b00)
            shoot++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge GCK1);
    endtask

    function automatic logic [31:0] ch(input int c);
        return {28'b0, driveHighLeft[c], driveLowLeft[c], driveHighRight[c], driveLowRight[c]};
    endfunction

    initial begin
        GSR1 = 1'b1; GTS1 = 1'b0; pwm = 2'b00; enable = 2'b00; brake = 2'b00;
        no_overcurrent = 1'b1; no_hardware_error = 1'b1; heatsink_temp_ok = 1'b1; fault_clear = 1'b0;
        #1 GSR1 = 1'b0;
        tick(2);
        chk("rst_latched", 32'(fault_latched), 1);
        chk("rst_ch0", ch(0), 4'h0);
        chk("rst_ch1", ch(1), 4'h0);
        GSR1 = 1'b1;
        tick(3);
        chk("power_up_latched", 32'(fault_latched), 1);
        fault_clear = 1'b1;
        tick(2);
        chk("clr_pending", 32'(fault_latched), 1);
        tick(1);
        chk("clr_done", 32'(fault_latched), 0);
        fault_clear = 1'b0;
        // ch0 forward: DEAD entered at E2, conducting at E14
        enable[0] = 1'b1; pwm[0] = 1'b1;
        tick(14);
        chk("fwd_dead_end", ch(0), 4'h0);
        tick(1);
        chk("fwd_on", ch(0), 4'h9);
        chk("fwd_ch1_idle", ch(1), 4'h0);
        // forward to reverse
        pwm[0] = 1'b0;
        tick(2);
        chk("rev_pre", ch(0), 4'h9);
        tick(1);
        chk("rev_dead", ch(0), 4'h0);
        tick(11);
        chk("rev_dead_end", ch(0), 4'h0);
        tick(1);
        chk("rev_on", ch(0), 4'h6);
        // brake pulse of 5 cycles; DEAD length stays 12, final state REV
        brake[0] = 1'b1;
        tick(3);
        chk("brk_dead", ch(0), 4'h0);
        tick(2);
        brake[0] = 1'b0;
        tick(9);
        chk("brk_dead_end", ch(0), 4'h0);
        tick(1);
        chk("brk_rev", ch(0), 4'h6);
        // ch1 forward, then single-cycle overcurrent
        enable[1] = 1'b1; pwm[1] = 1'b1;
        tick(15);
        chk("ch1_fwd", ch(1), 4'h9);
        no_overcurrent = 1'b0;
        tick(1);
        no_overcurrent = 1'b1;
        tick(1);
        chk("oc_pre_latched", 32'(fault_latched), 0);
        chk("oc_pre_ch0", ch(0), 4'h6);
        tick(1);
        chk("oc_latched", 32'(fault_latched), 1);
        chk("oc_ch0", ch(0), 4'h0);
        chk("oc_ch1", ch(1), 4'h0);
        // clear refused while heatsink fault present
        heatsink_temp_ok = 1'b0;
        tick(3);
        fault_clear = 1'b1;
        tick(4);
        chk("clr_refused", 32'(fault_latched), 1);
        fault_clear = 1'b0; heatsink_temp_ok = 1'b1;
        tick(3);
        chk("still_latched", 32'(fault_latched), 1);
        // valid clear: latch drops at E2, channels enter DEAD at E3, conduct at E15
        fault_clear = 1'b1;
        tick(3);
        chk("clr2_done", 32'(fault_latched), 0);
        chk("clr2_ch0_off", ch(0), 4'h0);
        tick(12);
        chk("clr2_dead_ch0", ch(0), 4'h0);
        chk("clr2_dead_ch1", ch(1), 4'h0);
        tick(1);
        chk("clr2_ch0", ch(0), 4'h6);
        chk("clr2_ch1", ch(1), 4'h9);
        fault_clear = 1'b0;
        // ch0 back to forward, then tristate
        pwm[0] = 1'b1;
        tick(15);
        chk("gts_pre", ch(0), 4'h9);
        GTS1 = 1'b1;
        #1;
        chk("gts_hl0", {31'b0, driveHighLeft[0] === 1'b1}, 0);
        chk("gts_lr0", {31'b0, driveLowRight[0] === 1'b1}, 0);
        chk("gts_hl1", {31'b0, driveHighLeft[1] === 1'b1}, 0);
        tick(3);
        GTS1 = 1'b0;
        #1;
        chk("gts_back_ch0", ch(0), 4'h9);
        chk("gts_back_ch1", ch(1), 4'h9);
        // asynchronous reset in the middle of DEAD
        pwm[0] = 1'b0;
        tick(8);
        chk("mid_dead", ch(0), 4'h0);
        #2 GSR1 = 1'b0;
        #1;
        chk("arst_latched", 32'(fault_latched), 1);
        chk("arst_ch0", ch(0), 4'h0);
        chk("arst_ch1", ch(1), 4'h0);
        tick(1);
        GSR1 = 1'b1;
        tick(20);
        chk("post_rst_latched", 32'(fault_latched), 1);
        chk("post_rst_ch0", ch(0), 4'h0);
        chk("post_rst_ch1", ch(1), 4'h0);
        chk("shoot_through", 32'(shoot), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
